// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants, types and helpers for the seven-segment scan path.
// The hex decoder downstream can reuse DIG_OFF and the nibble/digit types.
//   NUM_DIG_C  : digits scanned in this revision
//   NIBBLE_W   : bits per displayed hex digit
//   DIG_OFF    : active-low digit select with every digit disabled
//   onehot_low : active-low one-hot digit select for a digit index
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int NUM_DIG_C = 4;
  localparam int NIBBLE_W  = 4;
  localparam int IDX_W     = 2;
  localparam int VALUE_W   = NUM_DIG_C * NIBBLE_W;

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [NIBBLE_W-1:0]  nibble_t;
  typedef logic [NUM_DIG_C-1:0] dig_t;
  typedef logic [VALUE_W-1:0]   value_t;

  localparam dig_t DIG_OFF = 4'b1111;

  // Active-low select: only bit idx is driven low.
  function automatic dig_t onehot_low(input idx_t idx);
    return ~(dig_t'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scan_if
// Bundle between the value producer and the digit scanner.
//   value      : 16-bit hex value, nibble i belongs to digit i
//   load       : one-cycle strobe capturing value
//   blank_lz   : request leading-zero blanking
//   data       : nibble for the current scan slot (to the decoder)
//   dig        : active-low digit enables
//   frame_done : one-cycle pulse at the end of the last digit slot
// master = producer side, slave = scanner side.
// -----------------------------------------------------------------------------
interface seg_scan_if;
  import seg_pkg::*;

  value_t  value;
  logic    load;
  logic    blank_lz;
  nibble_t data;
  dig_t    dig;
  logic    frame_done;

  modport master (
    output value, load, blank_lz,
    input  data, dig, frame_done
  );

  modport slave (
    input  value, load, blank_lz,
    output data, dig, frame_done
  );

endinterface

// File: rtl/seg_prescaler.sv
// -----------------------------------------------------------------------------
// seg_prescaler
// Divides clk into one tick per digit slot.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   tick : high for the last cycle of each CLK_DIV-cycle slot
//          (high every cycle when CLK_DIV == 1)
// -----------------------------------------------------------------------------
module seg_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // A single-cycle slot still needs a one-bit counter to keep the code uniform.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == CNT_LAST);

endmodule

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Time-multiplexes a 16-bit hex value across NUM_DIG digits for the
// seven-segment decoder. New values are held in a pending register and only
// copied into the displayed (shadow) value at a frame boundary, so a frame
// never mixes digits of two values.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : seg_scan_if.slave
//         value/load/blank_lz in, data/dig/frame_done out (all registered)
// -----------------------------------------------------------------------------
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int NUM_DIG = NUM_DIG_C
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam idx_t LAST_IDX = idx_t'(NUM_DIG - 1);

  logic   tick;
  logic   wrap;
  idx_t   idx;
  value_t shadow;
  value_t pending;
  logic   pend_vld;
  dig_t   blank_vec;

  seg_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // End of the last digit slot: frame boundary where the shadow may change.
  assign wrap = tick && (idx == LAST_IDX);

  // Leading-zero blanking: digit i (i >= 1) goes dark when it and every more
  // significant nibble of the displayed value are zero. Digit 0 always shows.
  // NOTE: every signal written here gets a default before the loop, so no
  // path through the block leaves a value unassigned and no latch appears.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIG_C - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (shadow[i*NIBBLE_W +: NIBBLE_W] == '0);
      blank_vec[i] = bus.blank_lz && upper_zero;
    end
  end

  // NOTE: shadow and pending are ordinary flop registers rather than a memory
  // array, so they take part in reset like the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      shadow         <= '0;
      pending        <= '0;
      pend_vld       <= 1'b0;
      bus.data       <= '0;
      bus.dig        <= DIG_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end

      // Last load in a frame wins; the later wrap clause overrides pend_vld.
      if (bus.load) begin
        pending  <= bus.value;
        pend_vld <= 1'b1;
      end

      // A load landing exactly on the boundary bypasses pending.
      if (wrap && (pend_vld || bus.load)) begin
        shadow   <= bus.load ? bus.value : pending;
        pend_vld <= 1'b0;
      end

      // Outputs reflect the pre-edge slot and shadow; data keeps the nibble
      // even when the digit is blanked so the decoder input stays defined.
      bus.data       <= shadow[idx*NIBBLE_W +: NIBBLE_W];
      bus.dig        <= blank_vec[idx] ? DIG_OFF : onehot_low(idx);
      bus.frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan
// Two scanners share one stimulus: CLK_DIV=4 (main) and CLK_DIV=1.
// A behavioural model derives the expected outputs from the count of clock
// edges since reset, the committed value and the pending value.
// -----------------------------------------------------------------------------
module tb_seg_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;

  int tests;
  int fails;

  seg_scan_if ifc4 ();
  seg_scan_if ifc1 ();

  assign ifc4.value    = value;
  assign ifc4.load     = load;
  assign ifc4.blank_lz = blank_lz;
  assign ifc1.value    = value;
  assign ifc1.load     = load;
  assign ifc1.blank_lz = blank_lz;

  seg_scan #(.CLK_DIV(4), .NUM_DIG(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (ifc4.slave)
  );

  seg_scan #(.CLK_DIV(1), .NUM_DIG(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model, index 0 = CLK_DIV 4, index 1 = CLK_DIV 1.
  // k counts edges since reset; slot = (k / div) % 4; the frame ends when
  // (k + 1) is a multiple of 4*div.
  // ---------------------------------------------------------------------------
  int          m_k     [2];
  logic [15:0] m_shown [2];
  logic [15:0] m_pend  [2];
  bit          m_pv    [2];
  logic [3:0]  e_data  [2];
  logic [3:0]  e_dig   [2];
  logic        e_fd    [2];
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    int dv;
    int slot;
    bit last;
    bit blk;
    for (int d = 0; d < 2; d++) begin
      dv = (d == 0) ? 4 : 1;
      if (rst) begin
        m_k[d]     = 0;
        m_shown[d] = 16'h0;
        m_pend[d]  = 16'h0;
        m_pv[d]    = 1'b0;
        e_data[d]  = 4'h0;
        e_dig[d]   = 4'hF;
        e_fd[d]    = 1'b0;
      end else if (m_valid) begin
        slot      = (m_k[d] / dv) % 4;
        last      = ((m_k[d] + 1) % (4 * dv)) == 0;
        e_data[d] = 4'((m_shown[d] >> (4 * slot)) & 16'hF);
        blk       = blank_lz && (slot != 0) && ((m_shown[d] >> (4 * slot)) == 16'h0);
        e_dig[d]  = blk ? 4'hF : ~(4'b0001 << slot);
        e_fd[d]   = last;
        if (last) begin
          if (load)          m_shown[d] = value;
          else if (m_pv[d])  m_shown[d] = m_pend[d];
          m_pv[d] = 1'b0;
        end else if (load) begin
          m_pend[d] = value;
          m_pv[d]   = 1'b1;
        end
        m_k[d]++;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Compare process: outputs are stable on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("data4", ifc4.data, e_data[0]);
      check("dig4", ifc4.dig, e_dig[0]);
      check("fd4", ifc4.frame_done, e_fd[0]);
      check("data1", ifc1.data, e_data[1]);
      check("dig1", ifc1.dig, e_dig[1]);
      check("fd1", ifc1.frame_done, e_fd[1]);
      check("onehot1", 16'($countones(~ifc1.dig) <= 1), 16'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers (drive on the falling edge, sample at the same point)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (ifc4.frame_done === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL fd_timeout: frame_done never seen within 64 cycles, expected a pulse");
  endtask

  // Called at the falling edge where frame_done is high; checks the 4 slots
  // of the following frame. dg packs {dig3, dig2, dig1, dig0}.
  task automatic check_frame(input string name, input logic [15:0] v, input logic [15:0] dg);
    for (int s = 0; s < 4; s++) begin
      step((s == 0) ? 1 : 4);
      check({name, "_data"}, ifc4.data, v[4*s +: 4]);
      check({name, "_dig"}, ifc4.dig, dg[4*s +: 4]);
    end
  endtask

  logic [3:0] idle_dig [4];

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    value    = 16'h0;
    load     = 1'b0;
    blank_lz = 1'b0;
    idle_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset state
    step(3);
    check("rst_data", ifc4.data, 16'h0);
    check("rst_dig", ifc4.dig, 16'hF);
    check("rst_fd", ifc4.frame_done, 16'h0);

    // Idle scan: two frames, each digit held 4 cycles, frame_done every 16
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      step(1);
      check("idle_dig", ifc4.dig, 16'(idle_dig[(c / 4) % 4]));
      check("idle_fd", ifc4.frame_done, 16'((c % 16) == 15));
      check("idle_data", ifc4.data, 16'h0);
    end

    // Mid-frame load: current frame keeps old value, next frame shows it
    step(5);
    do_load(16'h1A3F);
    check("old_frame_data", ifc4.data, 16'h0);
    wait_fd();
    check_frame("v1a3f", 16'h1A3F, 16'h7BDE);

    // Two loads in one frame: the later one wins
    wait_fd();
    step(2);
    do_load(16'h1111);
    step(2);
    do_load(16'h2222);
    wait_fd();
    check_frame("v2222", 16'h2222, 16'h7BDE);

    // Load exactly on the wrap edge commits directly
    wait_fd();
    step(15);
    value = 16'h5555;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
    check("wrap_fd", ifc4.frame_done, 16'h1);
    check_frame("v5555", 16'h5555, 16'h7BDE);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0042);
    wait_fd();
    check_frame("blank42", 16'h0042, 16'hFFDE);
    do_load(16'h0000);
    wait_fd();
    check_frame("blank0", 16'h0000, 16'hFFFE);
    blank_lz = 1'b0;

    // Reset during digit 2 with a load pending
    wait_fd();
    do_load(16'hBEEF);
    step(8);
    check("pre_rst_dig", ifc4.dig, 16'hB);
    rst = 1'b1;
    step(1);
    check("mid_rst_data", ifc4.data, 16'h0);
    check("mid_rst_dig", ifc4.dig, 16'hF);
    rst = 1'b0;
    step(1);
    check("post_rst_dig", ifc4.dig, 16'hE);
    check("post_rst_data", ifc4.data, 16'h0);
    for (int i = 0; i < 40; i++) begin
      step(1);
      check("no_beef4", ifc4.data, 16'h0);
      check("no_beef1", ifc1.data, 16'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      load  = ($urandom_range(0, 9) == 0);
      if ((i % 97) == 0) blank_lz = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 999) == 0);
      step(1);
    end
    rst  = 1'b0;
    load = 1'b0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
